// File: rtl/map_pkg.sv
// map_pkg: shared tile codes, size defaults and FSM states for the map writer
package map_pkg;
  localparam int unsigned TILE_EMPTY = 0;
  localparam int unsigned TILE_RED = 1;
  localparam int unsigned TILE_YELLOW = 2;
  localparam int LANES_D = 5;
  localparam int ROWS_D = 100;
  localparam int TILE_W_D = 3;
  localparam int LEN_W = 11;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
endpackage

// File: rtl/map_tile_ram.sv
// map_tile_ram: single write port, registered read port tile store without array reset
module map_tile_ram #(
  parameter int DEPTH = 500,
  parameter int W = 3,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

// File: rtl/map_writer.sv
// map_writer: tile-stream map loader with masked registered reads; MAP_WRITER_TILE_CHECK_EN rejects codes above yellow
module map_writer
  import map_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int ROWS = ROWS_D,
  parameter int TILE_W = TILE_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tile_valid,
  input  logic [TILE_W-1:0] tile_data,
  input  logic              tile_last,
  output logic              tile_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  len,
  input  logic [6:0]        rd_y,
  input  logic [2:0]        rd_x,
  output logic [TILE_W-1:0] rd_state
);
  localparam int AW = $clog2(LANES * ROWS);
  localparam int LW = $clog2(LANES);
  localparam int RW = $clog2(ROWS);
  state_t state, nxt;
  logic [LW-1:0] lane;
  logic [RW-1:0] row;
  logic map_ok, rd_ok, acc, at_end, restart, bad_now, bad;
  logic [TILE_W-1:0] wdata, q;
  assign acc = tile_valid && state == LOAD;
  assign at_end = lane == LW'(LANES - 1);
  assign restart = start && state != LOAD;
  assign tile_ready = state == LOAD;
  assign busy = state == LOAD;
  assign done = state == DONE;
  assign err = state == ERR;
  assign rd_state = rd_ok ? q : TILE_W'(TILE_EMPTY);
`ifdef MAP_WRITER_TILE_CHECK_EN
  logic bad_tile;
  assign bad_now = acc && tile_data > TILE_W'(TILE_YELLOW);
  assign bad = bad_tile || bad_now;
  assign wdata = bad_now ? TILE_W'(TILE_EMPTY) : tile_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bad_tile <= 1'b0;
    else if (restart) bad_tile <= 1'b0;
    else if (bad_now) bad_tile <= 1'b1;
`else
  assign bad_now = 1'b0;
  assign bad = bad_now;
  assign wdata = tile_data;
`endif
  always_comb begin
    nxt = state;
    if (restart) nxt = LOAD;
    else if (acc && tile_last) nxt = (at_end && !bad) ? DONE : ERR;
    else if (acc && at_end && row == RW'(ROWS - 1)) nxt = ERR;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      row <= '0;
      len <= '0;
      map_ok <= 1'b0;
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= map_ok && 32'(rd_x) < LANES && LEN_W'(rd_y) < len;
      if (restart) begin
        lane <= '0;
        row <= '0;
        len <= '0;
        map_ok <= 1'b0;
      end else if (acc) begin
        lane <= at_end ? '0 : lane + LW'(1);
        row <= at_end ? row + RW'(1) : row;
        if (nxt == DONE) begin
          len <= LEN_W'(row) + LEN_W'(1);
          map_ok <= 1'b1;
        end
        if (nxt == ERR) begin
          len <= '0;
          map_ok <= 1'b0;
        end
      end
    end
  end
  map_tile_ram #(.DEPTH(LANES * ROWS), .W(TILE_W), .AW(AW)) u_ram (
    .clk(clk),
    .we(acc),
    .waddr(AW'(row) * AW'(LANES) + AW'(lane)),
    .wdata(wdata),
    .raddr(AW'(rd_y) * AW'(LANES) + AW'(rd_x)),
    .q(q)
  );
endmodule

// File: tb/tb_map_writer.sv
// tb_map_writer: directed self-checking bench for map_writer
module tb_map_writer;
  logic clk = 0, rst_n = 0, start = 0, tile_valid = 0, tile_last = 0;
  logic [2:0] tile_data = 0, rd_x = 0, rd_state;
  logic [6:0] rd_y = 0;
  logic tile_ready, busy, done, err;
  logic [10:0] len;
  int tests = 0, fails = 0;
  logic [2:0] r;
  map_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tile_valid(tile_valid), .tile_data(tile_data),
    .tile_last(tile_last), .tile_ready(tile_ready), .busy(busy), .done(done), .err(err),
    .len(len), .rd_y(rd_y), .rd_x(rd_x), .rd_state(rd_state)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] pat(int x, int y);
    return 3'((x + y) % 3);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start;
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic beat(input logic [2:0] d, input logic l);
    tile_valid = 1;
    tile_data = d;
    tile_last = l;
    tick;
    tile_valid = 0;
    tile_last = 0;
  endtask
  task automatic rd(input int x, input int y, output logic [2:0] v);
    rd_x = 3'(x);
    rd_y = 7'(y);
    tick;
    v = rd_state;
  endtask
  task automatic test_reset;
    tick;
    tests++; if (tile_ready !== 0) begin fails++; $display("FAIL reset_ready: got %b want 0", tile_ready); end
    tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    tests++; if (len !== 0) begin fails++; $display("FAIL reset_len: got %0d want 0", len); end
    tests++; if (rd_state !== 0) begin fails++; $display("FAIL reset_rd: got %0d want 0", rd_state); end
    rst_n = 1;
    tick;
  endtask
  task automatic test_clean_load;
    do_start;
    tests++; if ({busy, tile_ready} !== 2'b11) begin fails++; $display("FAIL load_busy: got %b want 11", {busy, tile_ready}); end
    for (int y = 0; y < 87; y++)
      for (int x = 0; x < 5; x++) beat(pat(x, y), y == 86 && x == 4);
    tests++; if ({done, err, busy, tile_ready} !== 4'b1000) begin fails++; $display("FAIL clean_flags: got %b want 1000", {done, err, busy, tile_ready}); end
    tests++; if (len !== 87) begin fails++; $display("FAIL clean_len: got %0d want 87", len); end
    rd(4, 86, r); tests++; if (r !== 0) begin fails++; $display("FAIL clean_rd_4_86: got %0d want 0", r); end
    rd(1, 2, r); tests++; if (r !== 0) begin fails++; $display("FAIL clean_rd_1_2: got %0d want 0", r); end
    rd(2, 86, r); tests++; if (r !== 1) begin fails++; $display("FAIL clean_rd_2_86: got %0d want 1", r); end
    rd(1, 1, r); tests++; if (r !== 2) begin fails++; $display("FAIL clean_rd_1_1: got %0d want 2", r); end
    rd(0, 87, r); tests++; if (r !== 0) begin fails++; $display("FAIL clean_rd_beyond_len: got %0d want 0", r); end
    rd(5, 0, r); tests++; if (r !== 0) begin fails++; $display("FAIL clean_rd_bad_lane: got %0d want 0", r); end
  endtask
  task automatic test_short_row;
    do_start;
    for (int i = 0; i < 7; i++) beat(3'd1, i == 6);
    tests++; if ({done, err} !== 2'b01) begin fails++; $display("FAIL short_flags: got %b want 01", {done, err}); end
    tests++; if (len !== 0) begin fails++; $display("FAIL short_len: got %0d want 0", len); end
    rd(0, 0, r); tests++; if (r !== 0) begin fails++; $display("FAIL short_rd: got %0d want 0", r); end
  endtask
  task automatic test_full_map;
    do_start;
    for (int i = 0; i < 500; i++) beat(pat(i % 5, i / 5), i == 499);
    tests++; if ({done, err} !== 2'b10) begin fails++; $display("FAIL full_flags: got %b want 10", {done, err}); end
    tests++; if (len !== 100) begin fails++; $display("FAIL full_len: got %0d want 100", len); end
    rd(4, 99, r); tests++; if (r !== 1) begin fails++; $display("FAIL full_rd_4_99: got %0d want 1", r); end
  endtask
  task automatic test_overflow;
    do_start;
    for (int i = 0; i < 499; i++) beat(3'd2, 1'b0);
    tests++; if ({busy, err} !== 2'b10) begin fails++; $display("FAIL ovf_499: got %b want 10", {busy, err}); end
    beat(3'd2, 1'b0);
    tests++; if ({err, done, tile_ready} !== 3'b100) begin fails++; $display("FAIL ovf_flags: got %b want 100", {err, done, tile_ready}); end
    tests++; if (len !== 0) begin fails++; $display("FAIL ovf_len: got %0d want 0", len); end
    tile_valid = 1;
    tile_last = 1;
    #1;
    tests++; if (tile_ready !== 0) begin fails++; $display("FAIL ovf_501_ready: got %b want 0", tile_ready); end
    tick;
    tile_valid = 0;
    tile_last = 0;
    tests++; if ({err, done} !== 2'b10) begin fails++; $display("FAIL ovf_501_state: got %b want 10", {err, done}); end
  endtask
  task automatic test_backpressure;
    int n = 0;
    bit pulsed = 0;
    do_start;
    while (n < 15) begin
      if ($urandom_range(0, 2) == 0) tick;
      else begin
        beat(pat(n % 5, n / 5), n == 14);
        n++;
      end
      if (n == 7 && !pulsed) begin
        pulsed = 1;
        do_start;
        tests++; if (busy !== 1) begin fails++; $display("FAIL bp_start_ignored: got %b want 1", busy); end
        rd(2, 0, r); tests++; if (r !== 0) begin fails++; $display("FAIL bp_rd_in_load: got %0d want 0", r); end
      end
    end
    tests++; if ({done, err} !== 2'b10) begin fails++; $display("FAIL bp_flags: got %b want 10", {done, err}); end
    tests++; if (len !== 3) begin fails++; $display("FAIL bp_len: got %0d want 3", len); end
    rd(4, 0, r); tests++; if (r !== 1) begin fails++; $display("FAIL bp_rd_4_0: got %0d want 1", r); end
    rd(1, 1, r); tests++; if (r !== 2) begin fails++; $display("FAIL bp_rd_1_1: got %0d want 2", r); end
    rd(0, 2, r); tests++; if (r !== 2) begin fails++; $display("FAIL bp_rd_0_2: got %0d want 2", r); end
  endtask
  task automatic test_reset_mid_load;
    do_start;
    for (int i = 0; i < 200; i++) beat(pat(i % 5, i / 5), 1'b0);
    #2 rst_n = 0;
    #1;
    tests++; if ({tile_ready, busy, done, err} !== 4'b0000) begin fails++; $display("FAIL rstmid_flags: got %b want 0000", {tile_ready, busy, done, err}); end
    tests++; if ({len, rd_state} !== 14'd0) begin fails++; $display("FAIL rstmid_len_rd: got %0d/%0d want 0/0", len, rd_state); end
    tick;
    rst_n = 1;
    rd(1, 1, r); tests++; if (r !== 0) begin fails++; $display("FAIL rstmid_masked: got %0d want 0", r); end
    do_start;
    for (int i = 0; i < 10; i++) beat(pat(i % 5, i / 5), i == 9);
    tests++; if (len !== 2) begin fails++; $display("FAIL rstmid_len2: got %0d want 2", len); end
    rd(1, 1, r); tests++; if (r !== 2) begin fails++; $display("FAIL rstmid_rd_1_1: got %0d want 2", r); end
    rd(0, 2, r); tests++; if (r !== 0) begin fails++; $display("FAIL rstmid_rd_y2: got %0d want 0", r); end
  endtask
  task automatic test_tile_code;
    do_start;
    beat(3'd1, 0); beat(3'd5, 0); beat(3'd2, 0); beat(3'd0, 0); beat(3'd1, 1);
`ifdef MAP_WRITER_TILE_CHECK_EN
    tests++; if ({done, err} !== 2'b01) begin fails++; $display("FAIL chk_flags: got %b want 01", {done, err}); end
    tests++; if (dut.u_ram.mem[1] !== 0) begin fails++; $display("FAIL chk_stored: got %0d want 0", dut.u_ram.mem[1]); end
`else
    tests++; if ({done, err} !== 2'b10) begin fails++; $display("FAIL nochk_flags: got %b want 10", {done, err}); end
    rd(1, 0, r); tests++; if (r !== 5) begin fails++; $display("FAIL nochk_rd: got %0d want 5", r); end
`endif
  endtask
  initial begin
    test_reset;
    test_clean_load;
    test_short_row;
    test_full_map;
    test_overflow;
    test_backpressure;
    test_reset_mid_load;
    test_tile_code;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
